// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, datapath
// select codes, FSM state encoding and the Moore control word layout.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // pc_write, pc_write_cond and ir_fetch are qualifiers that the top
  // combines with Mem_Ready / Zero to form the input-dependent strobes.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_fetch;
  } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_word.sv
// Moore decode: maps the controller state to its datapath control word.
module mips_ctrl_word
  import mips_pkg::*;
(
  input  logic [3:0]  state,
  output ctrl_word_t  cw
);

  always_comb begin
    cw = '0;
    case (state_t'(state))
      S_FETCH: begin
        cw.mem_req   = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALU_OP_ADD;
        cw.pc_src    = PC_SRC_ALU;
        cw.ir_fetch  = 1'b1;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH2;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADR, S_ADDI_EX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEM_WB: begin
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_req   = 1'b1;
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_EXECUTE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        cw.reg_dst   = 1'b1;
        cw.reg_write = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_REG;
        cw.alu_op        = ALU_OP_SUB;
        cw.pc_src        = PC_SRC_ALU_OUT;
        cw.pc_write_cond = 1'b1;
      end
      S_ADDI_WB: cw.reg_write = 1'b1;
      S_JUMP: begin
        cw.pc_src   = PC_SRC_JUMP;
        cw.pc_write = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// gating of the Moore control word by Mem_Ready, Zero and reset.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       Mem_Req,
  output logic       Mem_Write,
  output logic       IorD,
  output logic       IR_Write,
  output logic       PC_En,
  output logic [1:0] PC_Src,
  output logic       ALU_SrcA,
  output logic [1:0] ALU_SrcB,
  output logic [1:0] ALU_Op,
  output logic       Reg_Dst,
  output logic       Mem_to_Reg,
  output logic       Reg_Write,
  output logic       Illegal_Op
);

  state_t     state;
  state_t     state_next;
  state_t     state_eff;
  ctrl_word_t cw;
  logic       legal_op;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    legal_op = (Opcode == OP_LW)   || (Opcode == OP_SW)  ||
               (Opcode == OP_RTYPE) || (Opcode == OP_BEQ) ||
               (Opcode == OP_ADDI) || (Opcode == OP_J);
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:   state_next = Mem_Ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDI_EX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEM_ADR: state_next = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_next = Mem_Ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  state_next = Mem_Ready ? S_FETCH : S_MEM_WR;
      S_EXECUTE: state_next = S_ALU_WB;
      S_ADDI_EX: state_next = S_ADDI_WB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Under reset the datapath selects show FETCH values regardless of the
  // stored state; strobes with side effects are forced low below.
  assign state_eff = rst_n ? state : S_FETCH;

  mips_ctrl_word u_ctrl_word (
    .state (state_eff),
    .cw    (cw)
  );

  assign Mem_Req    = rst_n & cw.mem_req;
  assign Mem_Write  = rst_n & cw.mem_write;
  assign Reg_Write  = rst_n & cw.reg_write;
  assign IR_Write   = rst_n & cw.ir_fetch & Mem_Ready;
  assign PC_En      = rst_n & ((cw.ir_fetch & Mem_Ready) | cw.pc_write |
                               (cw.pc_write_cond & Zero));
  assign Illegal_Op = rst_n & (state == S_DECODE) & ~legal_op;

  assign IorD       = cw.iord;
  assign PC_Src     = cw.pc_src;
  assign ALU_SrcA   = cw.alu_src_a;
  assign ALU_SrcB   = cw.alu_src_b;
  assign ALU_Op     = cw.alu_op;
  assign Reg_Dst    = cw.reg_dst;
  assign Mem_to_Reg = cw.mem_to_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: the instruction-level model queues the expected control
// vector for every cycle; a negedge monitor pops and compares it.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       Mem_Ready;
  logic       Mem_Req, Mem_Write, IorD, IR_Write, PC_En;
  logic [1:0] PC_Src;
  logic       ALU_SrcA;
  logic [1:0] ALU_SrcB, ALU_Op;
  logic       Reg_Dst, Mem_to_Reg, Reg_Write, Illegal_Op;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned cycle  = 0;
  logic [15:0] exp_q[$];

  mips_multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Opcode     (Opcode),
    .Zero       (Zero),
    .Mem_Ready  (Mem_Ready),
    .Mem_Req    (Mem_Req),
    .Mem_Write  (Mem_Write),
    .IorD       (IorD),
    .IR_Write   (IR_Write),
    .PC_En      (PC_En),
    .PC_Src     (PC_Src),
    .ALU_SrcA   (ALU_SrcA),
    .ALU_SrcB   (ALU_SrcB),
    .ALU_Op     (ALU_Op),
    .Reg_Dst    (Reg_Dst),
    .Mem_to_Reg (Mem_to_Reg),
    .Reg_Write  (Reg_Write),
    .Illegal_Op (Illegal_Op)
  );

  always #5 clk = ~clk;

  // Vector layout: Mem_Req Mem_Write IorD IR_Write PC_En PC_Src ALU_SrcA
  // ALU_SrcB ALU_Op Reg_Dst Mem_to_Reg Reg_Write Illegal_Op
  function automatic logic [15:0] vec(input bit mreq, input bit mw, input bit iord,
                                      input bit irw, input bit pcen, input logic [1:0] pcsrc,
                                      input bit sa, input logic [1:0] sb, input logic [1:0] aop,
                                      input bit rd, input bit m2r, input bit rw, input bit ill);
    return {mreq, mw, iord, irw, pcen, pcsrc, sa, sb, aop, rd, m2r, rw, ill};
  endfunction

  always @(negedge clk) begin
    logic [15:0] act;
    logic [15:0] exp_v;
    cycle <= cycle + 1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act = {Mem_Req, Mem_Write, IorD, IR_Write, PC_En, PC_Src, ALU_SrcA,
             ALU_SrcB, ALU_Op, Reg_Dst, Mem_to_Reg, Reg_Write, Illegal_Op};
      checks++;
      if (act === exp_v) passed++;
      else $display("FAIL ctrl_vec cycle=%0d opcode=%b actual=%b required=%b",
                    cycle, Opcode, act, exp_v);
    end
  end

  task automatic cyc(input logic rn, input logic mr, input logic z, input logic [15:0] e);
    rst_n = rn;
    Mem_Ready = mr;
    Zero = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] reset_vec();
    return vec(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rbit(), rbit(), reset_vec());
  endtask

  // One instruction from FETCH to its last cycle. abort_at >= 0 applies
  // reset after that many Mem_Ready=0 cycles in the data-memory wait.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           input bit zb, input int abort_at);
    bit legal;
    bit is_lw;
    bit is_sw;
    Opcode = op;
    is_lw = (op == 6'b100011);
    is_sw = (op == 6'b101011);
    legal = is_lw || is_sw || op == 6'b000000 || op == 6'b000100 ||
            op == 6'b001000 || op == 6'b000010;
    for (int i = 0; i < wf; i++)
      cyc(1, 0, rbit(), vec(1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0));
    cyc(1, 1, rbit(), vec(1, 0, 0, 1, 1, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0));
    cyc(1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, !legal));
    if (!legal) return;
    if (is_lw || is_sw) begin
      cyc(1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0));
      for (int i = 0; i < wm; i++) begin
        if (i == abort_at) begin
          do_reset(1);
          return;
        end
        cyc(1, 0, rbit(), vec(1, is_sw, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0));
      end
      cyc(1, 1, rbit(), vec(1, is_sw, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0));
      if (is_lw)
        cyc(1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1, 0));
    end else if (op == 6'b000000) begin
      cyc(1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0));
      cyc(1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0));
    end else if (op == 6'b000100) begin
      cyc(1, rbit(), zb, vec(0, 0, 0, 0, zb, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0));
    end else if (op == 6'b001000) begin
      cyc(1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0));
      cyc(1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0));
    end else begin
      cyc(1, rbit(), rbit(), vec(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [6];
    logic [5:0] r;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    if ($urandom_range(0, 7) != 0) return ops[$urandom_range(0, 5)];
    do r = 6'($urandom_range(0, 63));
    while (r == 6'b100011 || r == 6'b101011 || r == 6'b000000 ||
           r == 6'b000100 || r == 6'b001000 || r == 6'b000010);
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    Opcode = 6'b0;
    Zero = 1'b0;
    Mem_Ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    run_instr(6'b000000, 0, 0, 0, -1);
    run_instr(6'b100011, 0, 3, 0, -1);
    run_instr(6'b000100, 0, 0, 1, -1);
    run_instr(6'b000100, 0, 0, 0, -1);
    run_instr(6'b111111, 0, 0, 0, -1);
    run_instr(6'b101011, 1, 4, 0, 2);
    run_instr(6'b100011, 0, 3, 0, 1);
    run_instr(6'b000010, 2, 0, 0, -1);
    run_instr(6'b001000, 0, 0, 0, -1);
    run_instr(6'b101011, 0, 0, 0, -1);
    for (int n = 0; n < 300; n++) begin
      int wm;
      int ab;
      wm = $urandom_range(0, 3);
      ab = ($urandom_range(0, 9) == 0 && wm > 0) ? $urandom_range(0, wm - 1) : -1;
      run_instr(pick_op(), $urandom_range(0, 2), wm, rbit(), ab);
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 2));
    end
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
